multicycle_ctrl: RTL and testbench

Multi-cycle controller for the reduced RISC-V datapath (register file, ALU operand mux, add/sub ALU with EQ flag). Owns the program counter and fetches instructions over a request/acknowledge instruction-memory port. Decodes `addi` and `bne`, drives the datapath control and address lines for one execute cycle per instruction, and samples `EQ` to resolve branches. Sits between instruction memory and the datapath; halts on any unsupported instruction.

---
 rtl/ctrl_pkg.sv | 24 ++
 rtl/imm_ext.sv | 25 ++
 rtl/multicycle_ctrl.sv | 132 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller.
//   state_e   : controller FSM states
//   imm_sel_e : immediate format selector for imm_ext
//   OP_* / F3_* : opcode and funct3 values of the supported instructions
package ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic {
    IMM_I = 1'b0,
    IMM_B = 1'b1
  } imm_sel_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

endpackage

// File: rtl/imm_ext.sv
// Immediate extraction and sign extension for the I and B formats.
// Ports:
//   instr : instruction word
//   sel   : IMM_I or IMM_B
//   imm   : sign-extended 32-bit immediate
module imm_ext
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_sel_e    sel,
  output logic [31:0] imm
);

  always_comb begin
    // NOTE: default assignment first so no path leaves imm unassigned (no latch).
    imm = '0;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle controller for the reduced RISC-V datapath (addi / bne).
// Fetches over a req/ack instruction port, executes each instruction in a
// single EXEC cycle and halts permanently on anything it cannot run.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   run                       : permits the next fetch
//   imem_req/addr/ack/rdata   : instruction-memory handshake
//   AD1, AD2, AD3, WE3        : register-file addresses and write enable
//   ALUSrc, ALUAdd, ImmOp     : ALU operand select, add/sub, immediate
//   EQ                        : ALU equality flag (used by bne)
//   pc, halted, instr_retired : program counter, sticky halt, retire pulse
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  AD1,
  output logic [4:0]  AD2,
  output logic [4:0]  AD3,
  output logic        WE3,
  output logic        ALUSrc,
  output logic        ALUAdd,
  output logic [31:0] ImmOp,
  input  logic        EQ,
  output logic [31:0] pc,
  output logic        halted,
  output logic        instr_retired
);

  state_e      state;
  logic [31:0] ir;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        is_addi, is_bne, legal;
  logic        in_exec, taken, misaligned, commit;
  logic [31:0] ext_imm, br_target, seq_pc;
  imm_sel_e    imm_sel;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign rd      = ir[11:7];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];

  assign is_addi = (opcode == OP_IMM)    && (funct3 == F3_ADDI);
  assign is_bne  = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
  assign legal   = is_addi || is_bne;
  assign imm_sel = is_bne ? IMM_B : IMM_I;

  imm_ext u_imm_ext (
    .instr (ir),
    .sel   (imm_sel),
    .imm   (ext_imm)
  );

  assign in_exec    = (state == S_EXEC);
  assign seq_pc     = pc + 32'd4;
  assign br_target  = pc + ext_imm;
  assign taken      = is_bne && !EQ;
  // B-immediates are always even, so only bit 1 can misalign the target.
  assign misaligned = taken && br_target[1];
  assign commit     = in_exec && legal && !misaligned;

  assign imem_req      = (state == S_FETCH);
  assign imem_addr     = pc;
  assign instr_retired = commit;

  // Datapath controls: decoded from state and IR only; all zero outside a
  // legal EXEC so illegal encodings never reach the register file.
  always_comb begin
    AD1    = '0;
    AD2    = '0;
    AD3    = '0;
    WE3    = 1'b0;
    ALUSrc = 1'b0;
    ALUAdd = 1'b0;
    ImmOp  = '0;
    if (in_exec && legal) begin
      AD1   = rs1;
      ImmOp = ext_imm;
      if (is_addi) begin
        AD3    = rd;
        ALUSrc = 1'b1;
        ALUAdd = 1'b1;
        WE3    = (rd != 5'd0);
      end else begin
        AD2 = rs2;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (commit) begin
            pc    <= taken ? br_target : seq_pc;
            state <= run ? S_FETCH : S_IDLE;
          end else begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Inputs change on the falling edge,
// outputs are checked 1 time unit later, well clear of the rising edge.
module tb_multicycle_ctrl;

  localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] NOP         = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] BNE_M4      = 32'hFE20_9EE3; // bne x1,x2,-4
  localparam logic [31:0] ADDI_X2_M1  = 32'hFFF0_8113; // addi x2,x1,-1
  localparam logic [31:0] BNE_P6      = 32'h0010_1363; // bne x0,x1,+6

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, EQ;
  logic [31:0] imem_rdata;
  logic        imem_req, WE3, ALUSrc, ALUAdd, halted, instr_retired;
  logic [31:0] imem_addr, ImmOp, pc;
  logic [4:0]  AD1, AD2, AD3;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .AD1           (AD1),
    .AD2           (AD2),
    .AD3           (AD3),
    .WE3           (WE3),
    .ALUSrc        (ALUSrc),
    .ALUAdd        (ALUAdd),
    .ImmOp         (ImmOp),
    .EQ            (EQ),
    .pc            (pc),
    .halted        (halted),
    .instr_retired (instr_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; imem_ack = 1'b0; imem_rdata = '0; EQ = 1'b0;

    // Reset held two cycles with run=1.
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_pc", pc, 32'h0);
      check("rst_req", imem_req, 1'b0);
      check("rst_we3", WE3, 1'b0);
      check("rst_halted", halted, 1'b0);
    end
    @(negedge clk); rst = 1'b0; #1;
    check("rel1_req", imem_req, 1'b0);
    @(negedge clk); #1;
    check("rel2_req", imem_req, 1'b1);
    check("rel2_addr", imem_addr, 32'h0);

    // addi x1,x0,5 with zero-wait ack.
    imem_ack = 1'b1; imem_rdata = ADDI_X1_5;
    @(negedge clk); imem_ack = 1'b0; #1;
    check("addi_ad1", AD1, 5'd0);
    check("addi_ad3", AD3, 5'd1);
    check("addi_imm", ImmOp, 32'd5);
    check("addi_alusrc", ALUSrc, 1'b1);
    check("addi_aluadd", ALUAdd, 1'b1);
    check("addi_we3", WE3, 1'b1);
    check("addi_ret", instr_retired, 1'b1);
    @(negedge clk); #1;
    check("addi_pc", pc, 32'd4);
    check("addi_req", imem_req, 1'b1);

    // addi to x0 must not write.
    imem_ack = 1'b1; imem_rdata = NOP;
    @(negedge clk); imem_ack = 1'b0; #1;
    check("nop_we3", WE3, 1'b0);
    check("nop_ret", instr_retired, 1'b1);
    @(negedge clk); #1;
    check("nop_pc", pc, 32'd8);

    // bne taken (EQ=0): 8 - 4 = 4.
    imem_ack = 1'b1; imem_rdata = BNE_M4; EQ = 1'b0;
    @(negedge clk); imem_ack = 1'b0; #1;
    check("bne_ad1", AD1, 5'd1);
    check("bne_ad2", AD2, 5'd2);
    check("bne_aluadd", ALUAdd, 1'b0);
    check("bne_alusrc", ALUSrc, 1'b0);
    check("bne_we3", WE3, 1'b0);
    check("bne_imm", ImmOp, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("bne_taken_pc", pc, 32'd4);

    // Back to pc 8, then bne not taken (EQ=1): 12.
    imem_ack = 1'b1; imem_rdata = NOP;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); #1;
    check("nop2_pc", pc, 32'd8);
    imem_ack = 1'b1; imem_rdata = BNE_M4; EQ = 1'b1;
    @(negedge clk); imem_ack = 1'b0; #1;
    check("bne_nt_ret", instr_retired, 1'b1);
    @(negedge clk); #1;
    check("bne_nt_pc", pc, 32'd12);

    // Three wait states; run dropped mid-fetch.
    EQ = 1'b0; run = 1'b0; imem_rdata = ADDI_X2_M1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check("ws_req", imem_req, 1'b1);
      check("ws_addr", imem_addr, 32'd12);
      if (i == 3) imem_ack = 1'b1;
    end
    @(negedge clk); imem_ack = 1'b0; #1;
    check("ws_ad3", AD3, 5'd2);
    check("ws_imm", ImmOp, 32'hFFFF_FFFF);
    check("ws_ret", instr_retired, 1'b1);
    @(negedge clk); #1;
    check("idle_req", imem_req, 1'b0);
    check("idle_pc", pc, 32'd16);

    // Ack pulsed in IDLE is ignored.
    imem_ack = 1'b1; imem_rdata = 32'h0;
    @(negedge clk); imem_ack = 1'b0; #1;
    check("idle_ack_req", imem_req, 1'b0);
    check("idle_ack_halted", halted, 1'b0);
    check("idle_ack_pc", pc, 32'd16);

    // Illegal instruction 0x00000000 halts.
    run = 1'b1;
    @(negedge clk); #1;
    check("ill_req", imem_req, 1'b1);
    check("ill_addr", imem_addr, 32'd16);
    imem_ack = 1'b1; imem_rdata = 32'h0;
    @(negedge clk); imem_ack = 1'b0; #1;
    check("ill_we3", WE3, 1'b0);
    check("ill_ret", instr_retired, 1'b0);
    repeat (3) begin
      @(negedge clk); imem_ack = 1'b1; #1;
      check("ill_halted", halted, 1'b1);
      check("ill_pc", pc, 32'd16);
      check("ill_req_hold", imem_req, 1'b0);
      check("ill_we3_hold", WE3, 1'b0);
    end
    imem_ack = 1'b0;

    // Reset clears halt; taken bne to misaligned target (0+6) halts.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("rst2_halted", halted, 1'b0);
    check("rst2_pc", pc, 32'h0);
    @(negedge clk); #1;
    check("mis_req", imem_req, 1'b1);
    imem_ack = 1'b1; imem_rdata = BNE_P6; EQ = 1'b0;
    @(negedge clk); imem_ack = 1'b0; #1;
    check("mis_imm", ImmOp, 32'd6);
    check("mis_ret", instr_retired, 1'b0);
    check("mis_we3", WE3, 1'b0);
    @(negedge clk); #1;
    check("mis_halted", halted, 1'b1);
    check("mis_pc", pc, 32'h0);
    check("mis_req_hold", imem_req, 1'b0);

    // Reset coincident with ack: nothing latched.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("ra_fetch_req", imem_req, 1'b1);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = ADDI_X1_5;
    @(negedge clk); rst = 1'b0; imem_ack = 1'b0; #1;
    check("ra_req", imem_req, 1'b0);
    check("ra_pc", pc, 32'h0);
    check("ra_we3", WE3, 1'b0);
    check("ra_ret", instr_retired, 1'b0);
    check("ra_ad3", AD3, 5'd0);
    @(negedge clk); #1;
    check("ra_refetch_req", imem_req, 1'b1);
    check("ra_refetch_pc", pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
